// File: rtl/crc_pkg.sv
// Shared CRC-16/MODBUS constants and the byte-update function used by the
// transmit and receive CRC instances as well as by reference models.
package crc_pkg;

    localparam logic [15:0] MODBUS_CRC_POLY = 16'hA001;
    localparam logic [15:0] MODBUS_CRC_INIT = 16'hFFFF;

    // Fold one byte into a reflected CRC-16 with an arbitrary generator.
    // The loop has a constant trip count, so it unrolls into one level of
    // combinational logic.
    function automatic logic [15:0] crc16_byte_poly(input logic [15:0] crc,
                                                    input logic [7:0]  data,
                                                    input logic [15:0] poly);
        logic [15:0] c;
        c = crc ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) begin
                c = (c >> 1) ^ poly;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    // Fold one byte into a CRC-16/MODBUS register.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc,
                                               input logic [7:0]  data);
        return crc16_byte_poly(crc, data, MODBUS_CRC_POLY);
    endfunction

endpackage

// File: rtl/crc.sv
// Byte-wide CRC-16 accumulator (MODBUS by default). One byte per cycle when
// crc_en is high; crc_out is the register itself with no combinational
// path from the inputs. rst presets the register asynchronously.
module crc
    import crc_pkg::*;
#(
    parameter logic [15:0] POLY = MODBUS_CRC_POLY,
    parameter logic [15:0] INIT = MODBUS_CRC_INIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data_in,
    input  logic        crc_en,
    output logic [15:0] crc_out
);

    logic [15:0] crc_d;
    logic [15:0] crc_q;

    // Next CRC value: advance by one whole byte when enabled, else hold.
    always_comb begin
        crc_d = crc_q;
        if (crc_en) begin
            crc_d = crc16_byte_poly(crc_q, data_in, POLY);
        end
    end

    // CRC register; reset takes priority over an enabled byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q <= INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_out = crc_q;

endmodule

// File: tb/tb_crc.sv
// Randomized self-checking bench for crc against a table-driven CRC-16/MODBUS
// reference model plus the published known-answer values.
module tb_crc;

    logic        clk;
    logic        rst;
    logic [7:0]  data_in;
    logic        crc_en;
    logic [15:0] crc_out;

    int tests_run;
    int tests_failed;

    logic [15:0] crc_tbl [256];
    logic [15:0] model;

    logic [7:0] frame   [6] = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01};
    logic [7:0] chk_str [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    crc dut (
        .clk     (clk),
        .rst     (rst),
        .data_in (data_in),
        .crc_en  (crc_en),
        .crc_out (crc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check16(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %04h expected %04h", tag, got, exp);
        end
    endtask

    // Classic lookup-table form: crc' = (crc >> 8) ^ T[(crc ^ byte) & 0xFF].
    function automatic logic [15:0] model_step(input logic [15:0] c, input logic [7:0] b);
        logic [7:0] idx;
        idx = c[7:0] ^ b;
        return (c >> 8) ^ crc_tbl[idx];
    endfunction

    // Present one enabled byte at a falling edge; returns at the next
    // falling edge, after the rising edge that consumed it.
    task automatic send(input logic [7:0] b);
        data_in = b;
        crc_en  = 1'b1;
        @(negedge clk);
        crc_en  = 1'b0;
        model   = model_step(model, b);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            data_in = 8'($urandom);
            crc_en  = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        check16("async_reset", crc_out, 16'hFFFF);
        @(negedge clk);
        rst   = 1'b0;
        model = 16'hFFFF;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        for (int n = 0; n < 256; n++) begin
            logic [15:0] r;
            r = 16'(n);
            for (int k = 0; k < 8; k++) begin
                r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
            end
            crc_tbl[n] = r;
        end

        rst     = 1'b1;
        crc_en  = 1'b0;
        data_in = 8'h00;
        model   = 16'hFFFF;
        repeat (3) @(negedge clk);
        check16("reset_state", crc_out, 16'hFFFF);
        rst = 1'b0;
        @(negedge clk);
        check16("idle_after_reset", crc_out, 16'hFFFF);

        // Modbus frame
        foreach (frame[i]) send(frame[i]);
        check16("frame", crc_out, 16'h0A84);
        check16("frame_model", crc_out, model);

        // Asynchronous reset between edges
        send(8'hA5);
        pulse_reset();

        // Check string
        foreach (chk_str[i]) send(chk_str[i]);
        check16("check_string", crc_out, 16'h4B37);
        pulse_reset();

        // Residue, then hold with changing data
        foreach (frame[i]) send(frame[i]);
        send(8'h84);
        send(8'h0A);
        check16("residue", crc_out, 16'h0000);
        for (int k = 0; k < 5; k++) begin
            idle(1);
            check16("hold", crc_out, 16'h0000);
        end

        // Reset and enable together: reset wins
        rst     = 1'b1;
        crc_en  = 1'b1;
        data_in = 8'h55;
        @(negedge clk);
        check16("rst_over_en", crc_out, 16'hFFFF);
        @(negedge clk);
        check16("rst_held", crc_out, 16'hFFFF);
        rst    = 1'b0;
        crc_en = 1'b0;
        model  = 16'hFFFF;
        foreach (frame[i]) send(frame[i]);
        check16("frame_after_rst", crc_out, 16'h0A84);

        // Gapped frame
        pulse_reset();
        foreach (frame[i]) begin
            send(frame[i]);
            idle($urandom_range(1, 3));
        end
        check16("gapped_frame", crc_out, 16'h0A84);

        // Random messages with random gaps and occasional mid-message reset
        for (int m = 0; m < 40; m++) begin
            int len;
            pulse_reset();
            len = $urandom_range(1, 24);
            for (int k = 0; k < len; k++) begin
                send(8'($urandom));
                check16("rand_byte", crc_out, model);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                if ($urandom_range(0, 30) == 0) pulse_reset();
            end
            check16("rand_msg", crc_out, model);
            // Append the CRC bytes, low first: residue must be zero.
            begin
                logic [15:0] tx;
                tx = model;
                send(tx[7:0]);
                send(tx[15:8]);
                check16("rand_residue", crc_out, 16'h0000);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/crc.md
CRC -- requirements
Module: crc

Interface
REQ-001 Parameter POLY, default 16'hA001, reflected CRC-16 generator polynomial (Modbus, 0x8005 bit-reversed).
REQ-002 Parameter INIT, default 16'hFFFF, register preset value applied on reset.
REQ-003 clk  input  1  sole clock; all state updates on rising edge (parent may drive it with an inverted system clock).
REQ-004 rst  input  1  reset, asynchronous, active-high; presets the CRC register.
REQ-005 data_in  input  8  data byte to accumulate, sampled on the rising clk edge.
REQ-006 crc_en  input  1  accumulate enable; when high, data_in is folded into the CRC on this edge.
REQ-007 crc_out  output  16  current CRC register value, registered; low byte is transmitted first on the wire.

Function
REQ-008 The block SHALL hold a 16-bit CRC register and drive crc_out directly from it, with no combinational path from inputs to output.
REQ-009 On a rising clk edge with rst low and crc_en high, the register SHALL take next = F(crc, data_in), visible on crc_out one edge later (latency 1 cycle per byte, throughput 1 byte/cycle).
REQ-010 F SHALL be: c = crc XOR {8'h00, data_in}; then 8 iterations, LSB first: if c[0] then c = (c >> 1) XOR POLY else c = c >> 1; result c.
REQ-011 F SHALL be implemented as a fully unrolled single-cycle combinational function (no multi-cycle bit-serial engine).
REQ-012 With crc_en low and rst low, the register SHALL hold its value indefinitely.
REQ-013 The register SHALL have no wrap or saturation: every enabled byte advances it; there is no byte counter or length limit.
REQ-014 rst and crc_en asserted together: rst SHALL win; the register SHALL be INIT and data_in SHALL be discarded.
REQ-015 rst held high for many cycles (parent holds it level during idle/address phases) SHALL keep the register at INIT; the first enabled edge after rst deasserts SHALL process data_in from INIT.
REQ-016 data_in SHALL be used whole (8 bits); no byte reflection or final XOR is applied (CRC-16/MODBUS: refin=refout=true, xorout=0).
REQ-017 Feeding a message followed by its own CRC bytes (low byte then high byte) SHALL leave the register at 16'h0000 (residue check usable by a receiver).

Reset
REQ-018 Asserting rst SHALL immediately, without waiting for clk, set the register and crc_out to INIT (16'hFFFF).
REQ-019 Reset mid-message SHALL abandon the partial CRC; no other state exists.
REQ-020 Deassertion of rst SHALL be treated as synchronous to clk by the parent; the block SHALL add no reset synchronizer.

Structure
REQ-021 A shared package crc_pkg SHALL hold MODBUS_CRC_POLY (16'hA001), MODBUS_CRC_INIT (16'hFFFF), and the pure function crc16_byte(crc, data) implementing F.
REQ-022 The package function SHALL be reusable by the receive-side and transmit-side CRC instances and by bench reference models.
REQ-023 No sub-module is required; the block is one register plus the package function.

Verification
REQ-024 Reset: pulse rst between clk edges -> crc_out = 16'hFFFF immediately, before the next edge.
REQ-025 Modbus frame: bytes 01 03 00 00 00 01 with crc_en high for 6 cycles -> crc_out = 16'h0A84 (wire order 84 0A).
REQ-026 Check string: ASCII "123456789" (31..39) consecutive -> crc_out = 16'h4B37.
REQ-027 Residue: 01 03 00 00 00 01 84 0A -> crc_out = 16'h0000; hold crc_en low 5 cycles with changing data_in -> value unchanged.
REQ-028 Precedence: rst and crc_en high together with data_in = 8'h55 -> crc_out = 16'hFFFF; after release, byte 01 03 ... sequence again yields 16'h0A84.
REQ-029 Gapped input: the REQ-025 frame with crc_en low 1-3 random cycles between bytes -> crc_out = 16'h0A84.
